// File: rtl/epd_pmic_sequencer.sv
// E-paper PMIC power sequencer: wakes the PMIC, programs VCOM over I2C once per
// power-on, then brings up the rails and VCOM in order and tears them down in reverse.
module epd_pmic_sequencer #(
  parameter int         VCOM_MV     = 2780,
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         WAKE_CYCLES = 20000,
  parameter int         PG_TIMEOUT  = 1000000,
  parameter int         COM_DELAY   = 5000,
  parameter int         RETRY_MAX   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       switch,
  input  logic       PWRGOOD,
  output logic       WAKEUP,
  output logic       PWRUP,
  output logic       PWRCOM,
  output logic       i2c_start,
  output logic [7:0] i2c_wr_data,
  output logic       i2c_stop,
  input  logic       i2c_byte_done,
  input  logic       i2c_nack,
  output logic       ready,
  output logic [1:0] fault
);

  localparam int         VCOM_DIV  = VCOM_MV / 10;
  localparam logic [8:0] VCOM_CODE = (VCOM_DIV > 511) ? 9'd511 : 9'(VCOM_DIV);

  localparam int CNT_MAX0 = (WAKE_CYCLES > COM_DELAY) ? WAKE_CYCLES : COM_DELAY;
  localparam int CNT_MAX  = (CNT_MAX0 > PG_TIMEOUT) ? CNT_MAX0 : PG_TIMEOUT;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W    = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PG_LAST   = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] COM_LAST  = CNT_W'(COM_DELAY - 1);

  typedef enum logic [2:0] {
    ST_OFF, ST_WAKE, ST_XFER, ST_PWR_ON, ST_COM_WAIT, ST_ACTIVE, ST_PWR_OFF, ST_FAULT
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0]         byte_idx, byte_idx_n;
  logic [RTY_W-1:0]   retry, retry_n;
  logic               idle, idle_n;       // one-cycle gap after a NACK
  logic               issued, issued_n;   // start already pulsed for this attempt
  logic               stop_req, stop_req_n;
  logic               rail_on;            // PWRUP was driven in the previous cycle
  logic [1:0]         fault_n;
  logic               off_pending;
  logic               retry_last;

  assign off_pending = stop_req | ~switch;
  assign retry_last  = (int'(retry) + 1) >= RETRY_MAX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      cnt      <= '0;
      byte_idx <= '0;
      retry    <= '0;
      idle     <= 1'b0;
      issued   <= 1'b0;
      stop_req <= 1'b0;
      rail_on  <= 1'b0;
      fault    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_n;
      cnt      <= cnt_n;
      byte_idx <= byte_idx_n;
      retry    <= retry_n;
      idle     <= idle_n;
      issued   <= issued_n;
      stop_req <= stop_req_n;
      rail_on  <= PWRUP;
      fault    <= fault_n;
    end
  end

  always_comb begin
    // NOTE: every next value defaults to its current value so no latch is inferred.
    state_n    = state;
    byte_idx_n = byte_idx;
    retry_n    = retry;
    idle_n     = idle;
    issued_n   = issued;
    stop_req_n = stop_req;
    fault_n    = fault;
    case (state)
      ST_OFF:  if (switch) state_n = ST_WAKE;
      ST_WAKE: begin
        if (!switch)               state_n = ST_OFF;
        else if (cnt >= WAKE_LAST) state_n = ST_XFER;
      end
      ST_XFER: begin
        stop_req_n = off_pending;
        if (idle) begin
          if (off_pending) state_n = ST_PWR_OFF;
          else             idle_n  = 1'b0;
        end else begin
          issued_n = 1'b1;
          if (i2c_nack) begin
            if (retry_last) begin
              state_n = ST_FAULT;
              fault_n = 2'd1;
            end else if (off_pending) begin
              state_n = ST_PWR_OFF;
            end else begin
              retry_n    = retry + 1'b1;
              idle_n     = 1'b1;
              issued_n   = 1'b0;
              byte_idx_n = 2'd0;
            end
          end else if (i2c_byte_done) begin
            if (byte_idx == 2'd3) state_n    = off_pending ? ST_PWR_OFF : ST_PWR_ON;
            else                  byte_idx_n = byte_idx + 2'd1;
          end
        end
      end
      ST_PWR_ON: begin
        if (!switch)             state_n = ST_PWR_OFF;
        else if (PWRGOOD)        state_n = ST_COM_WAIT;
        else if (cnt >= PG_LAST) begin
          state_n = ST_FAULT;
          fault_n = 2'd2;
        end
      end
      ST_COM_WAIT: begin
        if (!switch)              state_n = ST_PWR_OFF;
        else if (cnt >= COM_LAST) state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!PWRGOOD) begin
          state_n = ST_FAULT;
          fault_n = 2'd3;
        end else if (!switch) begin
          state_n = ST_PWR_OFF;
        end
      end
      ST_PWR_OFF: if (!PWRGOOD || cnt >= PG_LAST) state_n = ST_OFF;
      ST_FAULT: begin
        if (!switch) begin
          state_n = ST_OFF;
          fault_n = 2'd0;
        end
      end
      default: state_n = ST_OFF;
    endcase

    // Transfer bookkeeping only lives inside XFER, so entry from WAKE starts clean.
    if (state_n != ST_XFER) begin
      byte_idx_n = '0;
      retry_n    = '0;
      idle_n     = 1'b0;
      issued_n   = 1'b0;
      stop_req_n = 1'b0;
    end

    // Cycle counter restarts on every state change and saturates instead of wrapping.
    if (state_n != state) cnt_n = '0;
    else if (cnt == '1)   cnt_n = cnt;
    else                  cnt_n = cnt + 1'b1;
  end

  always_comb begin
    WAKEUP      = 1'b0;
    PWRUP       = 1'b0;
    PWRCOM      = 1'b0;
    ready       = 1'b0;
    i2c_start   = 1'b0;
    i2c_stop    = 1'b0;
    i2c_wr_data = 8'h00;
    case (state)
      ST_WAKE: WAKEUP = 1'b1;
      ST_XFER: begin
        WAKEUP = 1'b1;
        if (!idle) begin
          i2c_start = ~issued;
          i2c_stop  = (byte_idx == 2'd3);
          case (byte_idx)
            2'd0:    i2c_wr_data = {DEV_ADDR, 1'b0};
            2'd1:    i2c_wr_data = 8'h03;
            2'd2:    i2c_wr_data = VCOM_CODE[7:0];
            default: i2c_wr_data = {7'b0, VCOM_CODE[8]};
          endcase
        end
      end
      ST_PWR_ON, ST_COM_WAIT: begin
        WAKEUP = 1'b1;
        PWRUP  = 1'b1;
      end
      ST_ACTIVE: begin
        WAKEUP = 1'b1;
        PWRUP  = 1'b1;
        PWRCOM = 1'b1;
        ready  = 1'b1;
      end
      // VCOM drops on entry; the rail follows one cycle later, and only if it was up.
      ST_PWR_OFF: begin
        WAKEUP = 1'b1;
        PWRUP  = rail_on && (cnt == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_epd_pmic_sequencer.sv
// Randomised bench for epd_pmic_sequencer: an I2C engine stand-in with random ACK
// latencies and NACKs, a PMIC stand-in with random PWRGOOD timing, and expected timing from arithmetic.
module tb_epd_pmic_sequencer;

  localparam int VCOM_MV     = 2780;
  localparam int WAKE_CYCLES = 20;
  localparam int PG_TIMEOUT  = 200;
  localparam int COM_DELAY   = 50;
  localparam int RETRY_MAX   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       switch;
  logic       PWRGOOD;
  logic       WAKEUP, PWRUP, PWRCOM;
  logic       i2c_start, i2c_stop;
  logic [7:0] i2c_wr_data;
  logic       i2c_byte_done, i2c_nack;
  logic       ready;
  logic [1:0] fault;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         start_pulses = 0;
  logic [7:0] exp_bytes [4];

  epd_pmic_sequencer #(
    .VCOM_MV    (VCOM_MV),
    .WAKE_CYCLES(WAKE_CYCLES),
    .PG_TIMEOUT (PG_TIMEOUT),
    .COM_DELAY  (COM_DELAY),
    .RETRY_MAX  (RETRY_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .switch       (switch),
    .PWRGOOD      (PWRGOOD),
    .WAKEUP       (WAKEUP),
    .PWRUP        (PWRUP),
    .PWRCOM       (PWRCOM),
    .i2c_start    (i2c_start),
    .i2c_wr_data  (i2c_wr_data),
    .i2c_stop     (i2c_stop),
    .i2c_byte_done(i2c_byte_done),
    .i2c_nack     (i2c_nack),
    .ready        (ready),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (i2c_start === 1'b1) start_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rails(input string tag, input logic w, input logic u, input logic c);
    check({tag, "_wakeup"}, WAKEUP, w);
    check({tag, "_pwrup"},  PWRUP,  u);
    check({tag, "_pwrcom"}, PWRCOM, c);
  endtask

  task automatic wait_start(input int bound, output int waited);
    waited = 0;
    while (i2c_start !== 1'b1 && waited < bound) begin
      tick();
      waited++;
    end
    if (i2c_start !== 1'b1) check("start_seen", i2c_start, 1);
  endtask

  // Plays the I2C engine for one transaction; NACKs byte nack_byte, drops switch after drop_after.
  task automatic present(input int nack_byte, input int drop_after, output bit nacked);
    nacked = 1'b0;
    for (int b = 0; b < 4; b++) begin
      int d;
      d = $urandom_range(0, 3);
      for (int k = 0; k <= d; k++) begin
        check("wr_data", i2c_wr_data, exp_bytes[b]);
        check("stop",    i2c_stop,    b == 3);
        check("start",   i2c_start,   (b == 0) && (k == 0));
        if (k < d) tick();
      end
      if (b == nack_byte) begin
        i2c_nack = 1'b1;
        tick();
        i2c_nack = 1'b0;
        nacked = 1'b1;
        return;
      end
      i2c_byte_done = 1'b1;
      tick();
      i2c_byte_done = 1'b0;
      if (b == drop_after) switch = 1'b0;
    end
  endtask

  // switch on, program VCOM with nacks failed attempts, then PWRGOOD after pg_lat cycles (<0: never).
  task automatic bring_up(input int nacks, input int nack_byte, input int pg_lat);
    int w, base;
    bit nacked;
    base   = start_pulses;
    switch = 1'b1;
    wait_start(WAKE_CYCLES + 10, w);
    check("wake_len", w, WAKE_CYCLES + 1);
    check("wake_wakeup", WAKEUP, 1);
    for (int a = 0; a < RETRY_MAX; a++) begin
      present((a < nacks) ? nack_byte : -1, -1, nacked);
      if (!nacked || a == RETRY_MAX - 1) break;
      check("retry_idle", i2c_start, 0);
      wait_start(4, w);
      check("retry_gap", w, 1);
    end
    check("start_pulses", start_pulses - base, (nacks >= RETRY_MAX) ? RETRY_MAX : nacks + 1);
    if (nacks >= RETRY_MAX) begin
      check("fault_i2c", fault, 1);
      check_rails("fault_i2c", 0, 0, 0);
      return;
    end
    check_rails("pwr_on", 1, 1, 0);
    check("pwr_on_fault", fault, 0);
    if (pg_lat < 0) begin
      w = 0;
      while (fault == 2'd0 && w < PG_TIMEOUT + 10) begin
        tick();
        w++;
      end
      check("pg_timeout_len", w, PG_TIMEOUT);
      check("fault_pg", fault, 2);
      check_rails("fault_pg", 0, 0, 0);
      return;
    end
    repeat (pg_lat) tick();
    check("pre_pg_pwrcom", PWRCOM, 0);
    PWRGOOD = 1'b1;
    w = 0;
    while (PWRCOM !== 1'b1 && w < COM_DELAY + 10) begin
      tick();
      w++;
    end
    // One cycle for PWRGOOD to be sampled, then COM_DELAY cycles to PWRCOM.
    check("com_delay", w, COM_DELAY + 1);
    check("active_ready", ready, 1);
    check("active_fault", fault, 0);
    check_rails("active", 1, 1, 1);
  endtask

  task automatic power_down();
    switch = 1'b0;
    tick();
    check_rails("off_entry", 1, 1, 0);
    check("off_ready", ready, 0);
    tick();
    check_rails("off_rail", 1, 0, 0);
    repeat ($urandom_range(0, 5)) tick();
    check("off_hold_wakeup", WAKEUP, 1);
    PWRGOOD = 1'b0;
    tick();
    check_rails("off_done", 0, 0, 0);
  endtask

  task automatic pg_drop();
    PWRGOOD = 1'b0;
    tick();
    check("fault_lost", fault, 3);
    check_rails("fault_lost", 0, 0, 0);
    check("fault_lost_ready", ready, 0);
    clear_fault();
  endtask

  task automatic clear_fault();
    switch = 1'b0;
    tick();
    check("fault_clear", fault, 0);
    check_rails("fault_clear", 0, 0, 0);
  endtask

  initial begin
    int vc, w;
    bit nacked;
    vc = VCOM_MV / 10;
    if (vc > 511) vc = 511;
    exp_bytes[0] = 8'hD0;
    exp_bytes[1] = 8'h03;
    exp_bytes[2] = vc[7:0];
    exp_bytes[3] = {7'b0, vc[8]};

    rst_n = 1'b0;
    switch = 1'b0;
    PWRGOOD = 1'b0;
    i2c_byte_done = 1'b0;
    i2c_nack = 1'b0;
    repeat (3) tick();
    check_rails("reset", 0, 0, 0);
    check("reset_start", i2c_start, 0);
    check("reset_stop", i2c_stop, 0);
    check("reset_data", i2c_wr_data, 0);
    check("reset_ready", ready, 0);
    check("reset_fault", fault, 0);
    rst_n = 1'b1;
    tick();

    // Nominal bring-up with PWRGOOD 100 cycles after PWRUP, then orderly shutdown.
    bring_up(0, -1, 100);
    power_down();

    // Two NACKs on byte 1 then success; three NACKs exhaust the retries.
    bring_up(2, 1, 30);
    power_down();
    bring_up(3, 1, 0);
    clear_fault();

    // PWRGOOD never rises.
    bring_up(0, -1, -1);
    clear_fault();

    // PWRGOOD lost while ACTIVE.
    bring_up(0, -1, 10);
    pg_drop();

    // switch released during WAKE aborts before any transfer.
    w = start_pulses;
    switch = 1'b1;
    tick();
    check("abort_wakeup_on", WAKEUP, 1);
    repeat ($urandom_range(0, WAKE_CYCLES - 2)) tick();
    switch = 1'b0;
    tick();
    check("abort_wakeup_off", WAKEUP, 0);
    repeat (WAKE_CYCLES + 2) tick();
    check("abort_no_start", start_pulses - w, 0);

    // switch released mid-transfer: transaction completes, rails never come up.
    switch = 1'b1;
    wait_start(WAKE_CYCLES + 10, w);
    present(-1, 0, nacked);
    check_rails("xfer_drop", 1, 0, 0);
    tick();
    check_rails("xfer_drop_off", 0, 0, 0);

    // Asynchronous reset while byte 2 is on the bus, then a full resend.
    switch = 1'b1;
    wait_start(WAKE_CYCLES + 10, w);
    for (int b = 0; b < 2; b++) begin
      i2c_byte_done = 1'b1;
      tick();
      i2c_byte_done = 1'b0;
    end
    check("pre_reset_byte2", i2c_wr_data, exp_bytes[2]);
    #2 rst_n = 1'b0;
    #1;
    check_rails("async_reset", 0, 0, 0);
    check("async_reset_data", i2c_wr_data, 0);
    check("async_reset_start", i2c_start, 0);
    check("async_reset_stop", i2c_stop, 0);
    check("async_reset_ready", ready, 0);
    check("async_reset_fault", fault, 0);
    switch = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bring_up(0, -1, 5);
    power_down();

    // Random mix of retry counts, NACK positions, PWRGOOD latencies and endings.
    for (int it = 0; it < 8; it++) begin
      int nacks, nb, lat, ending;
      nacks  = $urandom_range(0, 3);
      nb     = $urandom_range(0, 3);
      lat    = $urandom_range(1, PG_TIMEOUT / 2);
      ending = $urandom_range(0, 2);
      if (ending == 2) lat = -1;
      bring_up(nacks, nb, lat);
      if (nacks >= RETRY_MAX || lat < 0) clear_fault();
      else if (ending == 0)              power_down();
      else                               pg_drop();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
